// File: rtl/dnoc_itf_in_rd_req_agu_pkg.sv
// Read-request head-flit field map, decoded header struct and FSM states
// shared by the read-request address generator and its loop sub-block.
// No ports; imported with import dnoc_pkg::*.
package dnoc_pkg;

  localparam int FLIT_W     = 256;
  localparam int FLD_W      = 13;   // width of every length / gap field
  localparam int NUM_LVL    = 4;

  localparam int DEST_LSB   = 0;
  localparam int DEST_W     = 4;
  localparam int RESP_BIT   = 4;
  localparam int MC_BIT     = 6;
  localparam int RET_LSB    = 7;
  localparam int RET_W      = 12;
  localparam int BASE_LSB   = 19;
  localparam int BASE_W     = 25;
  localparam int PP_EN_BIT  = 57;
  localparam int PP_NUM_LSB = 58;
  localparam int PP_NUM_W   = 11;
  localparam int PING_LSB   = 69;
  localparam int PONG_LSB   = 82;
  localparam int GAP_LSB    = 95;
  localparam int LEN_LSB    = 147;

  // MSB-first overlay of the 256-bit head flit; gap[0]/len[0] sit in the LSBs.
  typedef struct packed {
    logic [FLIT_W-LEN_LSB-NUM_LVL*FLD_W-1:0] rsvd_hi;
    logic [NUM_LVL-1:0][FLD_W-1:0]          len;
    logic [NUM_LVL-1:0][FLD_W-1:0]          gap;
    logic [FLD_W-1:0]                       pong_len;
    logic [FLD_W-1:0]                       ping_len;
    logic [PP_NUM_W-1:0]                    pp_num;
    logic                                   pp_en;
    logic [PP_EN_BIT-BASE_LSB-BASE_W-1:0]   rsvd_mid;
    logic [BASE_W-1:0]                      base;
    logic [RET_W-1:0]                       ret_id;
    logic                                   mc;
    logic [MC_BIT-RESP_BIT-2:0]             rsvd_lo;
    logic                                   resp;
    logic [DEST_W-1:0]                      dest;
  } dnoc_rd_hdr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dnoc_itf_in_rd_req_agu_loop.sv
// 4-level nested-loop address generator built from per-level accumulators.
// Latency: addr reflects a load or step on the cycle after it is sampled.
// Backpressure: holds its position whenever step is low.
// Ports: clk/rst; load latches base/len/gap and rewinds all counters;
//        step advances one beat (level 3 innermost); addr = base + sum(acc).
module dnoc_loop_agu
  import dnoc_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            step,
  input  logic [ADDR_W-1:0]               base,
  input  logic [NUM_LVL-1:0][FLD_W-1:0]   len,
  input  logic [NUM_LVL-1:0][ADDR_W-1:0]  gap,
  output logic [ADDR_W-1:0]               addr
);

  logic [ADDR_W-1:0]              base_q, base_d;
  logic [NUM_LVL-1:0][FLD_W-1:0]  lm1_q, lm1_d;   // effective length minus one
  logic [NUM_LVL-1:0][ADDR_W-1:0] gap_q, gap_d;
  logic [NUM_LVL-1:0][FLD_W-1:0]  cnt_q, cnt_d;
  logic [NUM_LVL-1:0][ADDR_W-1:0] acc_q, acc_d;   // i_k * gap_k, kept incrementally
  logic                           carry;

  always_comb begin
    base_d = base_q;
    lm1_d  = lm1_q;
    gap_d  = gap_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    carry  = 1'b0;
    if (load) begin
      base_d = base;
      gap_d  = gap;
      cnt_d  = '0;
      acc_d  = '0;
      for (int k = 0; k < NUM_LVL; k++) begin
        // a zero length behaves as a single-iteration level
        lm1_d[k] = (len[k] == '0) ? '0 : len[k] - 1'b1;
      end
    end else if (step) begin
      carry = 1'b1;
      for (int k = NUM_LVL-1; k >= 0; k--) begin
        if (carry) begin
          if (cnt_q[k] == lm1_q[k]) begin
            cnt_d[k] = '0;
            acc_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
            acc_d[k] = acc_q[k] + gap_q[k];
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      lm1_q  <= '0;
      gap_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      base_q <= base_d;
      lm1_q  <= lm1_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

  assign addr = base_q + acc_q[0] + acc_q[1] + acc_q[2] + acc_q[3];

endmodule

// File: rtl/dnoc_itf_in_rd_req_agu.sv
// Read-request head-flit receiver driving a ping/pong segmented SRAM address stream.
// Latency: first rd_valid one cycle after flit accept; req_done/hdr_err one cycle after the event.
// Backpressure: rd_ready low freezes the beat; req_ready is low for the whole request.
// Ports: req_* flit handshake in; rd_* address beats out (seg/pkt last, pp_sel);
//        resp_dst_id/resp_mc latched return route; busy, req_done, hdr_err status.
module dnoc_itf_in_rd_req_agu
  import dnoc_pkg::*;
#(
  parameter logic [3:0] NODE_ID = 4'd0,
  parameter int         ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [255:0]      req_flit,
  input  logic              req_valid,
  input  logic              req_last,
  output logic              req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_seg_last,
  output logic              rd_pkt_last,
  output logic              rd_pp_sel,
  output logic [11:0]       resp_dst_id,
  output logic              resp_mc,
  output logic              busy,
  output logic              req_done,
  output logic              hdr_err
);

  dnoc_rd_hdr_t hdr;
  state_e                  state_q, state_d;
  logic [FLD_W-1:0]        ping_len_q, ping_len_d, pong_len_q, pong_len_d;
  logic [FLD_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [PP_NUM_W-1:0]     pp_num_q, pp_num_d;     // effective segment count (>=1)
  logic [PP_NUM_W-1:0]     seg_idx_q, seg_idx_d;
  logic [RET_W-1:0]        resp_dst_id_q, resp_dst_id_d;
  logic                    resp_mc_q, resp_mc_d;
  logic                    req_done_q, req_done_d;
  logic                    hdr_err_q, hdr_err_d;

  logic                    accept, hdr_bad, agu_load, agu_step;
  logic [FLD_W-1:0]        seg_len;
  logic                    seg_last, last_seg, n1_ok, n2_ok;
  logic [PP_NUM_W:0]       n1, n2;
  logic [PP_NUM_W-1:0]     new_num;
  logic [NUM_LVL-1:0][ADDR_W-1:0] agu_gap;
  logic                    unused_hdr;

  assign hdr        = req_flit;
  assign unused_hdr = ^hdr;

  assign accept  = req_valid & req_ready;
  assign hdr_bad = hdr.resp | (hdr.dest != NODE_ID) | ~req_last;
  assign new_num = (!hdr.pp_en || hdr.pp_num == '0) ? PP_NUM_W'(1) : hdr.pp_num;

  // Segment bookkeeping: even segments use ping, odd use pong. Because lengths
  // alternate, at most one zero-length segment separates two live ones, so the
  // next live segment is either idx+1 or idx+2 (same parity as the current one).
  assign seg_len  = seg_idx_q[0] ? pong_len_q : ping_len_q;
  assign seg_last = (beat_cnt_q == seg_len - 1'b1);
  assign n1       = {1'b0, seg_idx_q} + (PP_NUM_W+1)'(1);
  assign n2       = {1'b0, seg_idx_q} + (PP_NUM_W+1)'(2);
  assign n1_ok    = (n1 < {1'b0, pp_num_q}) && ((n1[0] ? pong_len_q : ping_len_q) != '0);
  assign n2_ok    = (n2 < {1'b0, pp_num_q});
  assign last_seg = !n1_ok && !n2_ok;

  always_comb begin
    for (int k = 0; k < NUM_LVL; k++) agu_gap[k] = ADDR_W'(hdr.gap[k]);
  end

  always_comb begin
    state_d       = state_q;
    ping_len_d    = ping_len_q;
    pong_len_d    = pong_len_q;
    beat_cnt_d    = beat_cnt_q;
    pp_num_d      = pp_num_q;
    seg_idx_d     = seg_idx_q;
    resp_dst_id_d = resp_dst_id_q;
    resp_mc_d     = resp_mc_q;
    req_done_d    = 1'b0;
    hdr_err_d     = 1'b0;
    agu_load      = 1'b0;
    agu_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_bad) begin
            hdr_err_d = 1'b1;
          end else begin
            ping_len_d    = hdr.ping_len;
            pong_len_d    = hdr.pong_len;
            pp_num_d      = new_num;
            resp_dst_id_d = hdr.ret_id;
            resp_mc_d     = hdr.mc;
            beat_cnt_d    = '0;
            agu_load      = 1'b1;
            // An empty ping segment is skipped like any other empty segment.
            if (hdr.ping_len != '0) begin
              seg_idx_d = '0;
              state_d   = ST_RUN;
            end else if (new_num > PP_NUM_W'(1) && hdr.pong_len != '0) begin
              seg_idx_d = PP_NUM_W'(1);
              state_d   = ST_RUN;
            end else begin
              req_done_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (rd_ready) begin
          agu_step = 1'b1;
          if (!seg_last) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else if (last_seg) begin
            state_d    = ST_IDLE;
            req_done_d = 1'b1;
          end else begin
            beat_cnt_d = '0;
            seg_idx_d  = n1_ok ? n1[PP_NUM_W-1:0] : n2[PP_NUM_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ping_len_q    <= '0;
      pong_len_q    <= '0;
      beat_cnt_q    <= '0;
      pp_num_q      <= '0;
      seg_idx_q     <= '0;
      resp_dst_id_q <= '0;
      resp_mc_q     <= 1'b0;
      req_done_q    <= 1'b0;
      hdr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ping_len_q    <= ping_len_d;
      pong_len_q    <= pong_len_d;
      beat_cnt_q    <= beat_cnt_d;
      pp_num_q      <= pp_num_d;
      seg_idx_q     <= seg_idx_d;
      resp_dst_id_q <= resp_dst_id_d;
      resp_mc_q     <= resp_mc_d;
      req_done_q    <= req_done_d;
      hdr_err_q     <= hdr_err_d;
    end
  end

  dnoc_loop_agu #(.ADDR_W(ADDR_W)) u_loop_agu (
    .clk  (clk),
    .rst  (rst),
    .load (agu_load),
    .step (agu_step),
    .base (hdr.base[ADDR_W-1:0]),
    .len  (hdr.len),
    .gap  (agu_gap),
    .addr (rd_addr)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign rd_valid    = (state_q == ST_RUN);
  assign busy        = rd_valid;
  assign rd_seg_last = rd_valid & seg_last;
  assign rd_pkt_last = rd_valid & seg_last & last_seg;
  assign rd_pp_sel   = rd_valid & seg_idx_q[0];
  assign resp_dst_id = resp_dst_id_q;
  assign resp_mc     = resp_mc_q;
  assign req_done    = req_done_q;
  assign hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_dnoc_itf_in_rd_req_agu.sv
// Scoreboard bench for the read-request address generator.
// Expected beats come from a mixed-radix reference model when a flit is sent.
// Beats, stall stability and status pulses are checked on the falling edge.
module tb_dnoc_itf_in_rd_req_agu;

  typedef struct packed {
    logic [12:0] addr;
    logic        seg_last;
    logic        pkt_last;
    logic        pp_sel;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [255:0] req_flit;
  logic         req_valid;
  logic         req_last;
  logic         req_ready;
  logic [12:0]  rd_addr;
  logic         rd_valid;
  logic         rd_ready;
  logic         rd_seg_last;
  logic         rd_pkt_last;
  logic         rd_pp_sel;
  logic [11:0]  resp_dst_id;
  logic         resp_mc;
  logic         busy;
  logic         req_done;
  logic         hdr_err;

  int    n_chk = 0;
  int    n_fail = 0;
  int    beats_done = 0;
  int    cyc = 0;
  bit    done_due = 0;
  bit    err_due = 0;
  bit    first_due = 0;
  bit    bp_mode = 0;
  beat_t sb[$];
  beat_t e;

  dnoc_itf_in_rd_req_agu dut (
    .clk         (clk),
    .rst         (rst),
    .req_flit    (req_flit),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_seg_last (rd_seg_last),
    .rd_pkt_last (rd_pkt_last),
    .rd_pp_sel   (rd_pp_sel),
    .resp_dst_id (resp_dst_id),
    .resp_mc     (resp_mc),
    .busy        (busy),
    .req_done    (req_done),
    .hdr_err     (hdr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic logic [255:0] mk_flit(input logic [12:0] base, input logic [12:0] ping,
                                           input logic [12:0] pong, input logic [10:0] ppn,
                                           input logic ppen, input logic [3:0][12:0] len,
                                           input logic [3:0][12:0] gap, input logic [11:0] ret,
                                           input logic mc, input logic resp, input logic [3:0] dest);
    logic [255:0] f;
    f          = '0;
    f[43:19]   = {12'hA5A, base};   // upper base bits must be ignored
    f[56:44]   = 13'h1ABC;          // reserved junk
    f[81:69]   = ping;
    f[94:82]   = pong;
    f[68:58]   = ppn;
    f[57]      = ppen;
    f[146:95]  = gap;
    f[198:147] = len;
    f[18:7]    = ret;
    f[6]       = mc;
    f[4]       = resp;
    f[3:0]     = dest;
    return f;
  endfunction

  // Reference: beat b decomposes mixed-radix into (i0,i1,i2,i3), level 3 fastest.
  task automatic model_push(input logic [12:0] base, input logic [12:0] ping, input logic [12:0] pong,
                            input logic [10:0] ppn, input logic ppen, input logic [3:0][12:0] len,
                            input logic [3:0][12:0] gap, output int nb);
    int num, last_s, b, sl, tmp;
    int lv[4];
    logic [31:0] a;
    beat_t x;
    num = (!ppen || ppn == 0) ? 1 : int'(ppn);
    for (int k = 0; k < 4; k++) lv[k] = (len[k] == 0) ? 1 : int'(len[k]);
    last_s = -1;
    for (int s = 0; s < num; s++) begin
      sl = (s % 2 == 1) ? int'(pong) : int'(ping);
      if (sl != 0) last_s = s;
    end
    b = 0;
    for (int s = 0; s < num; s++) begin
      sl = (s % 2 == 1) ? int'(pong) : int'(ping);
      for (int j = 0; j < sl; j++) begin
        tmp = b;
        a   = 32'(base);
        for (int k = 3; k >= 0; k--) begin
          a   = a + 32'(tmp % lv[k]) * 32'(gap[k]);
          tmp = tmp / lv[k];
        end
        x.addr     = a[12:0];
        x.seg_last = (j == sl - 1);
        x.pkt_last = (j == sl - 1) && (s == last_s);
        x.pp_sel   = (s % 2 == 1);
        sb.push_back(x);
        b++;
      end
    end
    nb = b;
  endtask

  // Monitor: pending status pulses first, then the visible beat against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (done_due) begin
        check_eq("req_done", 32'(req_done), 32'd1);
        check_eq("ready_after_done", 32'(req_ready), 32'd1);
        done_due = 0;
      end else if (req_done) begin
        check_eq("req_done_spurious", 32'(req_done), 32'd0);
      end
      if (err_due) begin
        check_eq("hdr_err", 32'(hdr_err), 32'd1);
        err_due = 0;
      end else if (hdr_err) begin
        check_eq("hdr_err_spurious", 32'(hdr_err), 32'd0);
      end
      if (first_due) begin
        check_eq("first_beat_latency", 32'(rd_valid), 32'd1);
        first_due = 0;
      end
      if (rd_valid) begin
        check_eq("busy", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
          check_eq("beat_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          e = sb[0];
          check_eq("rd_addr", 32'(rd_addr), 32'(e.addr));
          check_eq("rd_seg_last", 32'(rd_seg_last), 32'(e.seg_last));
          check_eq("rd_pkt_last", 32'(rd_pkt_last), 32'(e.pkt_last));
          check_eq("rd_pp_sel", 32'(rd_pp_sel), 32'(e.pp_sel));
          if (rd_ready) begin
            void'(sb.pop_front());
            beats_done++;
            if (e.pkt_last) done_due = 1;
          end
        end
      end
    end
  end

  // rd_ready: always high, or low three cycles out of four under backpressure.
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rd_ready = (bp_mode == 0) ? 1'b1 : (cyc % 4 == 3);
    end
  end

  task automatic send(input logic [255:0] f, input logic last);
    int t;
    t = 0;
    req_flit  = f;
    req_last  = last;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 200);
    if (!req_ready) check_eq("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || done_due || first_due || busy) && t < 500) begin
      @(posedge clk);
      t++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [12:0] base, input logic [12:0] ping, input logic [12:0] pong,
                         input logic [10:0] ppn, input logic ppen, input logic [3:0][12:0] len,
                         input logic [3:0][12:0] gap, input logic [11:0] ret, input logic mc);
    int nb;
    model_push(base, ping, pong, ppn, ppen, len, gap, nb);
    send(mk_flit(base, ping, pong, ppn, ppen, len, gap, ret, mc, 1'b0, 4'd0), 1'b1);
    if (nb == 0) done_due = 1;
    else first_due = 1;
    wait_idle();
  endtask

  task automatic send_bad(input logic [255:0] f, input logic last);
    send(f, last);
    err_due = 1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("bad_flit_idle", 32'(busy), 32'd0);
    check_eq("bad_flit_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int start, t;
    rst       = 1'b1;
    req_flit  = '0;
    req_valid = 1'b0;
    req_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_resp_dst", 32'(resp_dst_id), 32'd0);
    check_eq("rst_resp_mc", 32'(resp_mc), 32'd0);
    check_eq("rst_flags", 32'({req_done, hdr_err, rd_seg_last, rd_pkt_last, rd_pp_sel}), 32'd0);
    @(posedge clk);
    #1;

    // linear
    run_req(13'h100, 13'd4, 13'd0, 11'd0, 1'b0, {13'd8, 13'd0, 13'd0, 13'd0},
            {13'd1, 13'd0, 13'd0, 13'd0}, 12'hABC, 1'b1);
    check_eq("resp_dst_id", 32'(resp_dst_id), 32'hABC);
    check_eq("resp_mc", 32'(resp_mc), 32'd1);
    // two-level
    run_req(13'h200, 13'd6, 13'd0, 11'd0, 1'b0, {13'd2, 13'd3, 13'd0, 13'd0},
            {13'd1, 13'h10, 13'd0, 13'd0}, 12'h123, 1'b0);
    check_eq("resp_dst_id2", 32'(resp_dst_id), 32'h123);
    // ping-pong 2/1/2
    run_req(13'h000, 13'd2, 13'd1, 11'd3, 1'b1, {13'd64, 13'd0, 13'd0, 13'd0},
            {13'd1, 13'd0, 13'd0, 13'd0}, 12'h321, 1'b0);
    // ping-pong with empty ping segments skipped, three active levels
    run_req(13'h500, 13'd0, 13'd3, 11'd4, 1'b1, {13'd2, 13'd2, 13'd2, 13'd0},
            {13'd1, 13'h10, 13'h100, 13'd0}, 12'h0F0, 1'b1);
    // pp_num zero counts as one segment
    run_req(13'h080, 13'd3, 13'd5, 11'd0, 1'b1, {13'd4, 13'd0, 13'd0, 13'd0},
            {13'd2, 13'd0, 13'd0, 13'd0}, 12'h00F, 1'b0);

    // backpressure with wrap at the top of the address space
    bp_mode = 1;
    run_req(13'h1FFE, 13'd4, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
            {13'd1, 13'd0, 13'd0, 13'd0}, 12'h456, 1'b0);
    // all four levels wrap and restart at base
    run_req(13'h1F00, 13'd18, 13'd0, 11'd0, 1'b0, {13'd2, 13'd2, 13'd2, 13'd2},
            {13'd1, 13'd4, 13'h10, 13'h40}, 12'h789, 1'b1);
    bp_mode = 0;

    // zero-length request completes without beats
    run_req(13'h010, 13'd0, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
            {13'd1, 13'd0, 13'd0, 13'd0}, 12'h9A9, 1'b0);
    check_eq("resp_dst_zero_len", 32'(resp_dst_id), 32'h9A9);

    // dropped flits: response flag, wrong destination, not last
    send_bad(mk_flit(13'h020, 13'd4, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
                     {13'd1, 13'd0, 13'd0, 13'd0}, 12'h555, 1'b1, 1'b1, 4'd0), 1'b1);
    send_bad(mk_flit(13'h020, 13'd4, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
                     {13'd1, 13'd0, 13'd0, 13'd0}, 12'h555, 1'b1, 1'b0, 4'd5), 1'b1);
    send_bad(mk_flit(13'h020, 13'd4, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
                     {13'd1, 13'd0, 13'd0, 13'd0}, 12'h555, 1'b1, 1'b0, 4'd0), 1'b0);
    check_eq("resp_dst_kept", 32'(resp_dst_id), 32'h9A9);
    check_eq("resp_mc_kept", 32'(resp_mc), 32'd0);

    // reset after two of eight beats
    start = beats_done;
    begin
      int nb;
      model_push(13'h300, 13'd8, 13'd0, 11'd0, 1'b0, {13'd8, 13'd0, 13'd0, 13'd0},
                 {13'd1, 13'd0, 13'd0, 13'd0}, nb);
    end
    send(mk_flit(13'h300, 13'd8, 13'd0, 11'd0, 1'b0, {13'd8, 13'd0, 13'd0, 13'd0},
                 {13'd1, 13'd0, 13'd0, 13'd0}, 12'h777, 1'b1, 1'b0, 4'd0), 1'b1);
    first_due = 1;
    t = 0;
    while (beats_done < start + 2 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check_eq("beats_before_reset", 32'(beats_done - start), 32'd2);
    #1;
    rst = 1'b1;
    sb.delete();
    done_due  = 0;
    first_due = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("midrst_resp_dst", 32'(resp_dst_id), 32'd0);
    @(posedge clk);
    #1;
    run_req(13'h040, 13'd3, 13'd0, 11'd0, 1'b0, {13'd4, 13'd0, 13'd0, 13'd0},
            {13'd1, 13'd0, 13'd0, 13'd0}, 12'h246, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1, "simulation time limit");
  end

endmodule
